axi_rt_cfg_sequencer: RTL and testbench
=======================================

Name: axi_rt_cfg_sequencer

Overview:
Sequences safe, atomic reconfiguration of the real-time unit's per-region read/write budgets and periods.
- Software writes into shadow registers through a valid/ready config port.
- A commit request triggers the sequence: upstream isolation, copy of all shadow values to the active set, a one-cycle period abort so counters restart, then de-isolation.
- Sits beside the RT unit, between the config register file and the unit's IMTU configuration inputs.

Parameters:
NumAddrRegions, 2, number of address regions (≥1)
PeriodWidth, 32, period counter width
BudgetWidth, 32, budget counter width
TimeoutWidth, 16, isolation timeout counter width
period_t, logic [PeriodWidth-1:0], period type
budget_t, logic [BudgetWidth-1:0], budget type
region_idx_t, logic [idx_width(NumAddrRegions)-1:0], region index type

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
cfg_valid_i  in  1  shadow write request
cfg_ready_o  out  1  shadow write accepted; high only in IDLE
cfg_region_i  in  region_idx_t  target region
cfg_write_i  in  1  1: write-direction counters, 0: read-direction
cfg_budget_i  in  budget_t  new budget
cfg_period_i  in  period_t  new period
commit_i  in  1  commit request (sampled in IDLE)
timeout_i  in  TimeoutWidth  isolation timeout in cycles; 0 = no timeout
busy_o  out  1  high while not in IDLE
done_o  out  1  one-cycle pulse when a commit sequence finishes
error_o  out  1  sticky; last commit timed out
isolate_o  out  1  isolation request to upstream isolation stage
isolated_i  in  1  upstream isolation complete
imtu_abort_o  out  1  one-cycle period abort to RT unit
w_budget_o, r_budget_o  out  NumAddrRegions x budget_t  active budgets
w_period_o, r_period_o  out  NumAddrRegions x period_t  active periods

Behaviour:
- Reset (rst_ni low at a clk_i edge):
  - state IDLE; shadow and active arrays '0.
  - isolate_o, imtu_abort_o, done_o, error_o, busy_o all 0.
- Shadow write:
  - Handshake completes on cfg_valid_i & cfg_ready_o.
  - Updates shadow[cfg_write_i][cfg_region_i] budget and period on the next edge.
  - cfg_region_i ≥ NumAddrRegions: accepted and discarded.
  - Active values are unaffected by shadow writes.
- FSM states: IDLE, ISOLATE, APPLY, RELEASE.
- IDLE:
  - commit_i → ISOLATE; clear error_o; load timeout counter with timeout_i.
  - A same-cycle accepted shadow write is included in that commit.
- ISOLATE:
  - isolate_o = 1.
  - isolated_i → APPLY.
  - Otherwise, if timeout_i captured ≠ 0, decrement the counter; on reaching 0, set error_o and go → RELEASE without applying.
  - If isolated_i and expiry occur in the same cycle, isolated_i wins.
- APPLY (exactly 1 cycle):
  - isolate_o = 1; imtu_abort_o = 1.
  - Active arrays take the shadow values at the end of the cycle.
  - → RELEASE.
- RELEASE:
  - isolate_o = 0.
  - Wait for !isolated_i; then done_o = 1 for one cycle and → IDLE.
- Latency: minimum commit is 4 cycles (commit_i sampled → done_o) when isolated_i responds in 1 cycle and drops in 1 cycle.
- busy_o = (state != IDLE).
- commit_i outside IDLE is ignored; it is not queued.
- Reset mid-sequence returns to IDLE with everything cleared; isolate_o drops on the next edge.
- Outputs isolate_o, imtu_abort_o and done_o are combinational decodes of the registered state.

Decomposition:
- axi_rt_pkg holds:
  - the rt_cfg_state_e enum (2-bit);
  - a cfg_entry_t struct {budget_t, period_t}, parameterised via the module's types;
  - the shared index-width function.
- One natural sub-module: axi_rt_cfg_shadow. It contains the shadow+active register array, with a write port and a bulk-copy strobe. The FSM and timeout counter stay in the top.

Test Plan:
- Reset with inputs toggling → all outputs 0, cfg_ready_o=1, active arrays 0.
- Write region 1 W budget=0x100 period=0x1000; commit; isolated_i rises 1 cycle after isolate_o and falls 1 cycle after release → active w_budget_o[1]=0x100, imtu_abort_o high exactly 1 cycle, done_o at cycle 4.
- Write shadow without commit → active unchanged; cfg_valid_i during ISOLATE → cfg_ready_o=0, no shadow change.
- timeout_i=5, isolated_i held low → error_o set after 5 ISOLATE cycles, active unchanged, no imtu_abort_o pulse, done_o pulses; next commit clears error_o.
- timeout_i=0, isolated_i after 1000 cycles → no error; apply succeeds.
- Assert rst_ni low during APPLY → next cycle IDLE, isolate_o=0, active arrays 0.

Source files
------------

// File: rtl/axi_rt_pkg.sv
// Shared definitions for the RT-unit configuration sequencer.
//   rt_cfg_state_e : commit sequencer state encoding (2-bit)
//   cfg_entry_t    : one budget/period pair at the default counter widths
//   idx_width()    : index width for a count of items; never below 1 bit
package axi_rt_pkg;

  typedef enum logic [1:0] {
    CfgIdle    = 2'd0,
    CfgIsolate = 2'd1,
    CfgApply   = 2'd2,
    CfgRelease = 2'd3
  } rt_cfg_state_e;

  localparam int unsigned DefaultBudgetWidth = 32;
  localparam int unsigned DefaultPeriodWidth = 32;

  // Reference layout. Modules with non-default widths declare a local entry
  // struct with the same field order.
  typedef struct packed {
    logic [DefaultBudgetWidth-1:0] budget;
    logic [DefaultPeriodWidth-1:0] period;
  } cfg_entry_t;

  function automatic int unsigned idx_width(input int unsigned num);
    return (num > 32'd1) ? unsigned'($clog2(num)) : 32'd1;
  endfunction

endpackage

// File: rtl/axi_rt_cfg_shadow.sv
// Shadow and active budget/period register sets for the RT unit.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   wr_en_i                write one shadow entry this cycle
//   wr_write_i             direction select: 1 write-direction, 0 read-direction
//   wr_region_i            target region; values >= NumAddrRegions are dropped
//   wr_budget_i/period_i   new shadow values
//   copy_i                 bulk copy of every shadow entry into the active set
//   w_/r_budget_o, w_/r_period_o  active values per region
module axi_rt_cfg_shadow
  import axi_rt_pkg::*;
#(
  parameter int unsigned NumAddrRegions = 2,
  parameter int unsigned BudgetWidth    = 32,
  parameter int unsigned PeriodWidth    = 32,
  localparam int unsigned RegionIdxWidth = idx_width(NumAddrRegions)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      wr_en_i,
  input  logic                                      wr_write_i,
  input  logic [RegionIdxWidth-1:0]                 wr_region_i,
  input  logic [BudgetWidth-1:0]                    wr_budget_i,
  input  logic [PeriodWidth-1:0]                    wr_period_i,
  input  logic                                      copy_i,
  output logic [NumAddrRegions-1:0][BudgetWidth-1:0] w_budget_o,
  output logic [NumAddrRegions-1:0][BudgetWidth-1:0] r_budget_o,
  output logic [NumAddrRegions-1:0][PeriodWidth-1:0] w_period_o,
  output logic [NumAddrRegions-1:0][PeriodWidth-1:0] r_period_o
);

  typedef struct packed {
    logic [BudgetWidth-1:0] budget;
    logic [PeriodWidth-1:0] period;
  } entry_t;

  // First index: direction (0 read, 1 write); second: region.
  entry_t shadow_q [2][NumAddrRegions];
  entry_t active_q [2][NumAddrRegions];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned d = 0; d < 2; d++) begin
        for (int unsigned r = 0; r < NumAddrRegions; r++) begin
          shadow_q[d][r] <= '0;
          active_q[d][r] <= '0;
        end
      end
    end else begin
      // Matching by comparison lets out-of-range regions fall through untouched.
      for (int unsigned d = 0; d < 2; d++) begin
        for (int unsigned r = 0; r < NumAddrRegions; r++) begin
          if (wr_en_i && (wr_write_i == 1'(d)) &&
              (wr_region_i == RegionIdxWidth'(r))) begin
            shadow_q[d][r] <= '{budget: wr_budget_i, period: wr_period_i};
          end
        end
      end
      if (copy_i) begin
        active_q <= shadow_q;
      end
    end
  end

  always_comb begin
    w_budget_o = '0;
    r_budget_o = '0;
    w_period_o = '0;
    r_period_o = '0;
    for (int unsigned r = 0; r < NumAddrRegions; r++) begin
      w_budget_o[r] = active_q[1][r].budget;
      w_period_o[r] = active_q[1][r].period;
      r_budget_o[r] = active_q[0][r].budget;
      r_period_o[r] = active_q[0][r].period;
    end
  end

endmodule

// File: rtl/axi_rt_cfg_sequencer.sv
// Atomic reconfiguration sequencer for the RT unit's per-region budgets and
// periods. Software fills shadow registers; a commit isolates upstream,
// copies shadow to active, pulses a period abort, then releases isolation.
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   cfg_valid_i/cfg_ready_o  shadow write handshake (ready only in IDLE)
//   cfg_region_i, cfg_write_i, cfg_budget_i, cfg_period_i  shadow write data
//   commit_i                 start a commit (sampled in IDLE only)
//   timeout_i                isolation timeout in cycles, 0 disables it
//   busy_o, done_o, error_o  sequence status; error_o is sticky per commit
//   isolate_o/isolated_i     upstream isolation request / acknowledge
//   imtu_abort_o             one-cycle period abort while applying
//   w_/r_budget_o, w_/r_period_o  active configuration per region
module axi_rt_cfg_sequencer
  import axi_rt_pkg::*;
#(
  parameter int unsigned NumAddrRegions = 2,
  parameter int unsigned PeriodWidth    = 32,
  parameter int unsigned BudgetWidth    = 32,
  parameter int unsigned TimeoutWidth   = 16,
  localparam int unsigned RegionIdxWidth = idx_width(NumAddrRegions)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      cfg_valid_i,
  output logic                                      cfg_ready_o,
  input  logic [RegionIdxWidth-1:0]                 cfg_region_i,
  input  logic                                      cfg_write_i,
  input  logic [BudgetWidth-1:0]                    cfg_budget_i,
  input  logic [PeriodWidth-1:0]                    cfg_period_i,
  input  logic                                      commit_i,
  input  logic [TimeoutWidth-1:0]                   timeout_i,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic                                      error_o,
  output logic                                      isolate_o,
  input  logic                                      isolated_i,
  output logic                                      imtu_abort_o,
  output logic [NumAddrRegions-1:0][BudgetWidth-1:0] w_budget_o,
  output logic [NumAddrRegions-1:0][BudgetWidth-1:0] r_budget_o,
  output logic [NumAddrRegions-1:0][PeriodWidth-1:0] w_period_o,
  output logic [NumAddrRegions-1:0][PeriodWidth-1:0] r_period_o
);

  rt_cfg_state_e           state_q;
  logic [TimeoutWidth-1:0] tmo_cnt_q;
  logic                    error_q;

  // A zero counter in ISOLATE means the commit was issued with timeout 0;
  // an enabled counter never sits at zero there because it exits on 1.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= CfgIdle;
      tmo_cnt_q <= '0;
      error_q   <= 1'b0;
    end else begin
      unique case (state_q)
        CfgIdle: begin
          if (commit_i) begin
            state_q   <= CfgIsolate;
            error_q   <= 1'b0;
            tmo_cnt_q <= timeout_i;
          end
        end
        CfgIsolate: begin
          if (isolated_i) begin
            state_q <= CfgApply;
          end else if (tmo_cnt_q != '0) begin
            tmo_cnt_q <= tmo_cnt_q - TimeoutWidth'(1);
            if (tmo_cnt_q == TimeoutWidth'(1)) begin
              error_q <= 1'b1;
              state_q <= CfgRelease;
            end
          end
        end
        CfgApply: begin
          state_q <= CfgRelease;
        end
        CfgRelease: begin
          if (!isolated_i) begin
            state_q <= CfgIdle;
          end
        end
        default: state_q <= CfgIdle;
      endcase
    end
  end

  assign cfg_ready_o  = (state_q == CfgIdle);
  assign busy_o       = (state_q != CfgIdle);
  assign isolate_o    = (state_q == CfgIsolate) || (state_q == CfgApply);
  assign imtu_abort_o = (state_q == CfgApply);
  assign done_o       = (state_q == CfgRelease) && !isolated_i;
  assign error_o      = error_q;

  axi_rt_cfg_shadow #(
    .NumAddrRegions (NumAddrRegions),
    .BudgetWidth    (BudgetWidth),
    .PeriodWidth    (PeriodWidth)
  ) u_shadow (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wr_en_i     (cfg_valid_i && cfg_ready_o),
    .wr_write_i  (cfg_write_i),
    .wr_region_i (cfg_region_i),
    .wr_budget_i (cfg_budget_i),
    .wr_period_i (cfg_period_i),
    .copy_i      (state_q == CfgApply),
    .w_budget_o  (w_budget_o),
    .r_budget_o  (r_budget_o),
    .w_period_o  (w_period_o),
    .r_period_o  (r_period_o)
  );

endmodule

// File: tb/tb_axi_rt_cfg_sequencer.sv
// Directed, table-driven bench for axi_rt_cfg_sequencer (3 regions so that
// an out-of-range region index is reachable).
module tb_axi_rt_cfg_sequencer;

  localparam int unsigned N  = 3;
  localparam int unsigned BW = 32;
  localparam int unsigned PW = 32;
  localparam int unsigned TW = 16;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    cfg_valid_i;
  logic                    cfg_ready_o;
  logic [1:0]              cfg_region_i;
  logic                    cfg_write_i;
  logic [BW-1:0]           cfg_budget_i;
  logic [PW-1:0]           cfg_period_i;
  logic                    commit_i;
  logic [TW-1:0]           timeout_i;
  logic                    busy_o, done_o, error_o, isolate_o, isolated_i, imtu_abort_o;
  logic [N-1:0][BW-1:0]    w_budget_o, r_budget_o;
  logic [N-1:0][PW-1:0]    w_period_o, r_period_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int abort_cnt = 0;

  axi_rt_cfg_sequencer #(
    .NumAddrRegions (N),
    .PeriodWidth    (PW),
    .BudgetWidth    (BW),
    .TimeoutWidth   (TW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_region_i (cfg_region_i),
    .cfg_write_i  (cfg_write_i),
    .cfg_budget_i (cfg_budget_i),
    .cfg_period_i (cfg_period_i),
    .commit_i     (commit_i),
    .timeout_i    (timeout_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .isolate_o    (isolate_o),
    .isolated_i   (isolated_i),
    .imtu_abort_o (imtu_abort_o),
    .w_budget_o   (w_budget_o),
    .r_budget_o   (r_budget_o),
    .w_period_o   (w_period_o),
    .r_period_o   (r_period_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (imtu_abort_o) abort_cnt <= abort_cnt + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]    region;
    logic          wr;
    logic [BW-1:0] budget;
    logic [PW-1:0] period;
  } wr_vec_t;

  typedef struct {
    logic          wr;
    int            region;
    logic [BW-1:0] budget;
    logic [PW-1:0] period;
  } exp_vec_t;

  wr_vec_t  wv [6];
  exp_vec_t ev [6];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] act_budget(input logic wr, input int r);
    return wr ? w_budget_o[r] : r_budget_o[r];
  endfunction

  function automatic logic [PW-1:0] act_period(input logic wr, input int r);
    return wr ? w_period_o[r] : r_period_o[r];
  endfunction

  task automatic chk_all_active_zero(input string name);
    for (int r = 0; r < N; r++) begin
      chk({name, "_wb"}, 64'(w_budget_o[r]), 64'h0);
      chk({name, "_wp"}, 64'(w_period_o[r]), 64'h0);
      chk({name, "_rb"}, 64'(r_budget_o[r]), 64'h0);
      chk({name, "_rp"}, 64'(r_period_o[r]), 64'h0);
    end
  endtask

  // Commit with isolated_i answering within the first ISOLATE cycle and
  // dropping one cycle into RELEASE; done_o is expected in cycle 4.
  task automatic commit_min(input string name);
    int abort_before;
    abort_before = abort_cnt;
    commit_i = 1'b1;
    tick();                                 // cycle 1: ISOLATE
    commit_i    = 1'b0;
    cfg_valid_i = 1'b0;
    chk({name, "_c1_isolate"}, 64'(isolate_o), 64'h1);
    chk({name, "_c1_busy"},    64'(busy_o),    64'h1);
    chk({name, "_c1_ready"},   64'(cfg_ready_o), 64'h0);
    chk({name, "_c1_error"},   64'(error_o),   64'h0);
    chk({name, "_c1_abort"},   64'(imtu_abort_o), 64'h0);
    isolated_i = 1'b1;
    tick();                                 // cycle 2: APPLY
    chk({name, "_c2_abort"},   64'(imtu_abort_o), 64'h1);
    chk({name, "_c2_isolate"}, 64'(isolate_o), 64'h1);
    tick();                                 // cycle 3: RELEASE, still isolated
    chk({name, "_c3_isolate"}, 64'(isolate_o), 64'h0);
    chk({name, "_c3_abort"},   64'(imtu_abort_o), 64'h0);
    chk({name, "_c3_done"},    64'(done_o),    64'h0);
    tick();                                 // cycle 4: isolation drops
    isolated_i = 1'b0;
    #1;
    chk({name, "_c4_done"},    64'(done_o),    64'h1);
    tick();                                 // back in IDLE
    chk({name, "_c5_done"},    64'(done_o),    64'h0);
    chk({name, "_c5_busy"},    64'(busy_o),    64'h0);
    chk({name, "_c5_ready"},   64'(cfg_ready_o), 64'h1);
    chk({name, "_abort_once"}, 64'(abort_cnt - abort_before), 64'h1);
  endtask

  initial begin
    int abort_before;

    wv[0] = '{region: 2'd0, wr: 1'b1, budget: 32'h11,   period: 32'h22};
    wv[1] = '{region: 2'd2, wr: 1'b0, budget: 32'h33,   period: 32'h44};
    wv[2] = '{region: 2'd2, wr: 1'b1, budget: 32'hDEAD, period: 32'hBEEF};
    wv[3] = '{region: 2'd3, wr: 1'b1, budget: 32'hFFFF, period: 32'hFFFF};
    wv[4] = '{region: 2'd1, wr: 1'b0, budget: 32'h77,   period: 32'h88};
    wv[5] = '{region: 2'd0, wr: 1'b0, budget: 32'h99,   period: 32'hAA};

    ev[0] = '{wr: 1'b1, region: 0, budget: 32'h11,   period: 32'h22};
    ev[1] = '{wr: 1'b1, region: 1, budget: 32'h100,  period: 32'h1000};
    ev[2] = '{wr: 1'b1, region: 2, budget: 32'hDEAD, period: 32'hBEEF};
    ev[3] = '{wr: 1'b0, region: 0, budget: 32'h99,   period: 32'hAA};
    ev[4] = '{wr: 1'b0, region: 1, budget: 32'h77,   period: 32'h88};
    ev[5] = '{wr: 1'b0, region: 2, budget: 32'h33,   period: 32'h44};

    // Reset with toggling inputs.
    rst_ni = 1'b0; timeout_i = '0; isolated_i = 1'b0;
    cfg_valid_i = 1'b0; commit_i = 1'b0; cfg_write_i = 1'b0;
    cfg_region_i = '0; cfg_budget_i = '0; cfg_period_i = '0;
    for (int i = 0; i < 4; i++) begin
      cfg_valid_i  = i[0];
      commit_i     = ~i[0];
      isolated_i   = i[1];
      cfg_write_i  = i[1];
      cfg_region_i = 2'(i);
      cfg_budget_i = $urandom;
      cfg_period_i = $urandom;
      tick();
    end
    chk("rst_isolate", 64'(isolate_o), 64'h0);
    chk("rst_abort",   64'(imtu_abort_o), 64'h0);
    chk("rst_busy",    64'(busy_o), 64'h0);
    chk("rst_error",   64'(error_o), 64'h0);
    chk("rst_ready",   64'(cfg_ready_o), 64'h1);
    cfg_valid_i = 1'b0; commit_i = 1'b0; isolated_i = 1'b0;
    #1;
    chk("rst_done",    64'(done_o), 64'h0);
    rst_ni = 1'b1;
    tick();
    chk_all_active_zero("rst");

    // Basic commit: region 1 W budget 0x100 period 0x1000.
    cfg_valid_i = 1'b1; cfg_region_i = 2'd1; cfg_write_i = 1'b1;
    cfg_budget_i = 32'h100; cfg_period_i = 32'h1000;
    tick();
    cfg_valid_i = 1'b0;
    chk("pre_commit_w1", 64'(w_budget_o[1]), 64'h0);
    commit_min("basic");
    chk("basic_w1_budget", 64'(w_budget_o[1]), 64'h100);
    chk("basic_w1_period", 64'(w_period_o[1]), 64'h1000);

    // Shadow write without commit; writes during ISOLATE are refused.
    cfg_valid_i = 1'b1; cfg_region_i = 2'd0; cfg_write_i = 1'b0;
    cfg_budget_i = 32'h55; cfg_period_i = 32'h66;
    tick();
    cfg_valid_i = 1'b0;
    tick(); tick();
    chk("nocommit_r0_budget", 64'(r_budget_o[0]), 64'h0);
    chk("nocommit_r0_period", 64'(r_period_o[0]), 64'h0);
    commit_i = 1'b1;
    tick();                                 // ISOLATE
    commit_i = 1'b0;
    cfg_valid_i = 1'b1; cfg_budget_i = 32'hAA; cfg_period_i = 32'hBB;
    #1;
    chk("iso_ready", 64'(cfg_ready_o), 64'h0);
    isolated_i = 1'b1;
    tick();                                 // APPLY
    chk("apply_ready", 64'(cfg_ready_o), 64'h0);
    tick();                                 // RELEASE
    cfg_valid_i = 1'b0;
    isolated_i  = 1'b0;
    #1;
    chk("refuse_done", 64'(done_o), 64'h1);
    tick();
    chk("refuse_r0_budget", 64'(r_budget_o[0]), 64'h55);
    chk("refuse_r0_period", 64'(r_period_o[0]), 64'h66);

    // Table: several writes, one out of range, last one same cycle as commit.
    for (int i = 0; i < 6; i++) begin
      cfg_valid_i  = 1'b1;
      cfg_region_i = wv[i].region;
      cfg_write_i  = wv[i].wr;
      cfg_budget_i = wv[i].budget;
      cfg_period_i = wv[i].period;
      if (i < 5) tick();
    end
    chk("tbl_pre_w0", 64'(w_budget_o[0]), 64'h0);
    commit_min("tbl");
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("tbl_budget_%0d", i), 64'(act_budget(ev[i].wr, ev[i].region)), 64'(ev[i].budget));
      chk($sformatf("tbl_period_%0d", i), 64'(act_period(ev[i].wr, ev[i].region)), 64'(ev[i].period));
    end

    // Timeout: 5 cycles with no acknowledge.
    cfg_valid_i = 1'b1; cfg_region_i = 2'd1; cfg_write_i = 1'b1;
    cfg_budget_i = 32'h123; cfg_period_i = 32'h456;
    tick();
    cfg_valid_i = 1'b0;
    timeout_i = 16'd5;
    abort_before = abort_cnt;
    commit_i = 1'b1;
    tick();                                 // ISOLATE cycle 1
    commit_i = 1'b0;
    for (int k = 2; k <= 5; k++) tick();    // ISOLATE cycles 2..5
    chk("tmo_c5_isolate", 64'(isolate_o), 64'h1);
    chk("tmo_c5_error",   64'(error_o), 64'h0);
    tick();                                 // RELEASE
    chk("tmo_error",   64'(error_o), 64'h1);
    chk("tmo_isolate", 64'(isolate_o), 64'h0);
    chk("tmo_done",    64'(done_o), 64'h1);
    tick();                                 // IDLE
    chk("tmo_idle_busy",  64'(busy_o), 64'h0);
    chk("tmo_sticky",     64'(error_o), 64'h1);
    chk("tmo_no_abort",   64'(abort_cnt - abort_before), 64'h0);
    chk("tmo_w1_kept",    64'(w_budget_o[1]), 64'h100);
    commit_min("clr_err");
    chk("clr_err_w1", 64'(w_budget_o[1]), 64'h123);

    // Timeout disabled, very late acknowledge.
    timeout_i = '0;
    cfg_valid_i = 1'b1; cfg_region_i = 2'd1; cfg_write_i = 1'b1;
    cfg_budget_i = 32'h200; cfg_period_i = 32'h2000;
    tick();
    cfg_valid_i = 1'b0;
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    for (int k = 0; k < 1000; k++) tick();
    chk("late_isolate", 64'(isolate_o), 64'h1);
    chk("late_error",   64'(error_o), 64'h0);
    isolated_i = 1'b1;
    tick();
    chk("late_abort", 64'(imtu_abort_o), 64'h1);
    tick();
    isolated_i = 1'b0;
    #1;
    chk("late_done", 64'(done_o), 64'h1);
    tick();
    chk("late_error_end", 64'(error_o), 64'h0);
    chk("late_w1_budget", 64'(w_budget_o[1]), 64'h200);
    chk("late_w1_period", 64'(w_period_o[1]), 64'h2000);

    // Reset asserted during APPLY.
    cfg_valid_i = 1'b1; cfg_region_i = 2'd2; cfg_write_i = 1'b0;
    cfg_budget_i = 32'h5A; cfg_period_i = 32'hA5;
    tick();
    cfg_valid_i = 1'b0;
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    isolated_i = 1'b1;
    tick();                                 // APPLY
    chk("rstapply_abort", 64'(imtu_abort_o), 64'h1);
    rst_ni = 1'b0;
    tick();
    chk("rstapply_isolate", 64'(isolate_o), 64'h0);
    chk("rstapply_busy",    64'(busy_o), 64'h0);
    chk("rstapply_abort0",  64'(imtu_abort_o), 64'h0);
    chk_all_active_zero("rstapply");
    rst_ni = 1'b1;
    isolated_i = 1'b0;
    tick();
    chk("rstapply_ready", 64'(cfg_ready_o), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
